// File: rtl/display_pkg.sv
// Shared display types and helpers: digit index, one-hot enable, BCD nibble.
// Kept generic so other display blocks can reuse the index-to-enable mapping.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0]      digit_idx_t;
    typedef logic [NUM_DIGITS-1:0] digit_en_t;
    typedef logic [3:0]            bcd_t;

    function automatic digit_en_t idx_to_onehot(input digit_idx_t i);
        digit_en_t r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/scan_timebase.sv
// Slot timebase: cycle counter within a slot, digit index, and end-of-slot strobe.
module scan_timebase
    import display_pkg::*;
#(
    parameter int DIV   = 100_000,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output digit_idx_t       idx,
    output logic             slot_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    assign slot_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: frame-shadowed digit data, per-digit
// blank/blink on the enable, and a dead time at the start of every slot.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV          = 100_000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_SLOTS  = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output digit_en_t               digit_en,
    output bcd_t                    bcd_out,
    output logic                    dp_out,
    output logic                    scan_tick
);

    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);
    localparam digit_idx_t         IDX_LAST   = digit_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic             slot_end;
    logic             frame_end;

    scan_timebase #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .cnt      (cnt),
        .idx      (idx),
        .slot_end (slot_end)
    );

    assign frame_end = slot_end && (idx == IDX_LAST);

    // Shadow copy taken on the last cycle of a frame so a frame never tears.
    logic [NUM_DIGITS-1:0][3:0] digits_sh;
    logic [NUM_DIGITS-1:0]      dp_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_sh <= '0;
            dp_sh     <= '0;
        end else if (frame_end) begin
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
        end
    end

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Phase toggles on the same edge the slot wraps, so the new slot sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (slot_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic in_dead;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    logic dark;
    assign dark = in_dead | blank_mask[idx] | (blink_mask[idx] & blink_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_en  <= '0;
            bcd_out   <= '0;
            dp_out    <= 1'b0;
            scan_tick <= 1'b0;
        end else begin
            digit_en  <= dark ? '0 : idx_to_onehot(idx);
            bcd_out   <= digits_sh[idx];
            dp_out    <= dp_sh[idx];
            scan_tick <= (cnt == '0);
        end
    end

endmodule
